// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode constants, instruction format codes and the
// registered decode bundle. Optional illegal-opcode flag under DECODE_ILLEGAL_CHK_EN.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd_addr;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        fmt_t       fmt;
        logic       rd_we;
`ifdef DECODE_ILLEGAL_CHK_EN
        logic       illegal;
`endif
    } bundle_t;

    // Unknown opcodes fall back to R so they carry a zero immediate.
    function automatic fmt_t opcode_fmt(input logic [6:0] opcode, input logic rv64);
        fmt_t f;
        f = FMT_R;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                   f = FMT_U;
            OPC_JAL:                              f = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:             f = FMT_I;
            OPC_STORE:                            f = FMT_S;
            OPC_BRANCH:                           f = FMT_B;
            OPC_OP:                               f = FMT_R;
            OPC_OP_IMM_32:                        f = rv64 ? FMT_I : FMT_R;
            default:                              f = FMT_R;
        endcase
        return f;
    endfunction

    function automatic logic opcode_known(input logic [6:0] opcode, input logic rv64);
        logic k;
        k = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_OP:
                k = 1'b1;
            OPC_OP_IMM_32, OPC_OP_32:
                k = rv64;
            default:
                k = 1'b0;
        endcase
        return k;
    endfunction

    function automatic logic opcode_writes_rd(input logic [6:0] opcode,
                                              input logic [2:0] funct3,
                                              input logic       rv64);
        logic w;
        w = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP:
                w = 1'b1;
            OPC_OP_IMM_32, OPC_OP_32:
                w = rv64;
            OPC_SYSTEM:
                w = (funct3 != 3'd0);
            default:
                w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational format classification and sign-extended immediate extraction.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_t            fmt,
    output logic [XLEN-1:0] imm
);

    localparam logic RV64 = (XLEN == 32'd64);

    logic [31:0] imm32;

    always_comb begin
        fmt   = opcode_fmt(instr[6:0], RV64);
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'h000};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // All formats produce a 32-bit signed value; widen by sign for RV64.
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// Single registered decode stage with valid/ready handshake and flush.
// Optional out_illegal port enabled by DECODE_ILLEGAL_CHK_EN.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd_addr,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rd_we
`ifdef DECODE_ILLEGAL_CHK_EN
    ,
    output logic            out_illegal
`endif
);

    localparam logic RV64 = (XLEN == 32'd64);

    logic            valid_q;
    logic [PC_W-1:0] pc_q;
    bundle_t         bundle_q;
    bundle_t         bundle_d;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] imm_d;
    fmt_t            fmt_d;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt_d),
        .imm   (imm_d)
    );

    always_comb begin
        bundle_d          = '0;
        bundle_d.opcode   = in_instr[6:0];
        bundle_d.funct3   = in_instr[14:12];
        bundle_d.funct7   = in_instr[31:25];
        bundle_d.rd_addr  = in_instr[11:7];
        bundle_d.rs1_addr = in_instr[19:15];
        bundle_d.rs2_addr = in_instr[24:20];
        bundle_d.fmt      = fmt_d;
        bundle_d.rd_we    = (in_instr[11:7] != 5'd0) &&
                            opcode_writes_rd(in_instr[6:0], in_instr[14:12], RV64);
`ifdef DECODE_ILLEGAL_CHK_EN
        bundle_d.illegal  = !opcode_known(in_instr[6:0], RV64) ||
                            (in_instr[1:0] != 2'b11);
`endif
    end

    assign in_ready = !valid_q || out_ready;

    // Flush only kills valid; data registers are left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            bundle_q <= '0;
            imm_q    <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                pc_q     <= in_pc;
                bundle_q <= bundle_d;
                imm_q    <= imm_d;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_opcode   = bundle_q.opcode;
    assign out_funct3   = bundle_q.funct3;
    assign out_funct7   = bundle_q.funct7;
    assign out_rd_addr  = bundle_q.rd_addr;
    assign out_rs1_addr = bundle_q.rs1_addr;
    assign out_rs2_addr = bundle_q.rs2_addr;
    assign out_imm      = imm_q;
    assign out_fmt      = bundle_q.fmt;
    assign out_rd_we    = bundle_q.rd_we;
`ifdef DECODE_ILLEGAL_CHK_EN
    assign out_illegal  = bundle_q.illegal;
`endif

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath/immediate width; legal values 32 and 64.
REQ-002 Parameter PC_W, default 32, program-counter width carried alongside the instruction.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  discard held instruction (branch redirect/trap).
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_instr  input  32  raw instruction word.
REQ-009 in_pc  input  PC_W  instruction address.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  downstream accepts bundle.
REQ-012 out_pc  output  PC_W  registered in_pc.
REQ-013 out_opcode/out_funct3/out_funct7  output  7/3/7  instr[6:0]/[14:12]/[31:25].
REQ-014 out_rd_addr/out_rs1_addr/out_rs2_addr  output  5 each  instr[11:7]/[19:15]/[24:20].
REQ-015 out_imm  output  XLEN  format-selected immediate, sign-extended to XLEN.
REQ-016 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-017 out_rd_we  output  1  instruction writes a nonzero rd.
REQ-018 out_illegal  output  1  unrecognised opcode (present only with DECODE_ILLEGAL_CHK_EN).

Function
REQ-019 Single registered stage; bundle appears on outputs the cycle after the in_valid&&in_ready handshake (latency 1).
REQ-020 in_ready = !out_valid || out_ready (combinational; full-throughput, no bubble on simultaneous drain and fill).
REQ-021 While out_valid && !out_ready, all out_* fields hold stable.
REQ-022 Format map: LUI 0110111, AUIPC 0010111 -> U; JAL 1101111 -> J; JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, SYSTEM 1110011 -> I; STORE 0100011 -> S; BRANCH 1100011 -> B; OP 0110011 -> R; when XLEN=64 also OP-IMM-32 0011011 -> I, OP-32 0111011 -> R; any other opcode -> R.
REQ-023 Immediates: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended from instr[31] to XLEN.
REQ-024 U = {instr[31:12],12'h000} sign-extended from bit 31 to XLEN; R format yields out_imm = 0.
REQ-025 out_rd_we = 1 iff rd_addr != 0 and opcode is LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, (XLEN=64: OP-IMM-32, OP-32), or SYSTEM with funct3 != 0.
REQ-026 flush asserted: out_valid cleared next cycle; flush has priority over a simultaneous input handshake (incoming instruction dropped).
REQ-027 Data fields need not be cleared on flush; only out_valid is architecturally significant.

Reset
REQ-028 rst high: out_valid = 0, out_pc = 0, all decoded fields = 0, out_illegal = 0; rst has priority over flush and handshake.
REQ-029 rst mid-transfer discards held bundle; in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro DECODE_ILLEGAL_CHK_EN defined: out_illegal port exists, = 1 for opcodes outside REQ-022 list or instr[1:0] != 2'b11; registered with the bundle.
REQ-031 Macro undefined: out_illegal port and its logic absent; all other behaviour identical.

Structure
REQ-032 Shared package holds opcode localparams, format-code enum (R/I/S/B/U/J), and the decoded-bundle struct.
REQ-033 Combinational field/immediate extraction in one sub-module imm_gen (instr, XLEN -> fmt, imm); decode_stage owns handshake and pipeline register.

Verification
REQ-034 XLEN=32, in_instr 0xFFF00093 (addi x1,x0,-1) -> next cycle out_fmt=1, out_imm=0xFFFFFFFF, out_rd_addr=1, out_rd_we=1.
REQ-035 in_instr 0xFFDFF0EF (jal x1,-4) -> out_fmt=5, out_imm=0xFFFFFFFC, out_rd_we=1.
REQ-036 XLEN=64, in_instr 0x800002B7 (lui x5,0x80000) -> out_fmt=4, out_imm=0xFFFFFFFF80000000.
REQ-037 Accept instr A, hold out_ready=0 three cycles -> in_ready=0, outputs stable A; raise out_ready with B valid -> A consumed, B shown next cycle, no bubble.
REQ-038 flush with in_valid=1 and bundle held -> next cycle out_valid=0; rst asserted mid-stream -> all outputs 0 next cycle.
REQ-039 With DECODE_ILLEGAL_CHK_EN, in_instr 0x00000000 -> out_illegal=1, out_fmt=0, out_imm=0; 0x00000013 -> out_illegal=0.
